debounce_bank: RTL and testbench

Parametrised multi-channel debouncer for the board's push-buttons and slide switches. Each channel synchronises a raw asynchronous input, filters contact bounce with its own stability counter, and presents a clean level plus single-cycle press, release and long-press event strobes. It sits between the board pins and the user logic, replacing per-button hand-wired debounce instances with one block sized by parameter.

---
 rtl/debounce_bank.sv | 56 +++++
 tb/tb_debounce_bank.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: per-channel 2-flop sync, bounce filter and press/release/long-press strobes (clk, reset, btn_in -> level_out, rise_pulse, fall_pulse, long_press)
module debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 50000,
  parameter int LONG_CYCLES   = 0,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] long_press
);
  localparam int CW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);
  logic [CHANNELS-1:0] s1, s2;
  always_ff @(posedge clk)
    if (reset) {s2, s1} <= '0;
    else {s2, s1} <= {s1, btn_in ^ {CHANNELS{ACTIVE_LOW != 0}}};
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic lvl, rise, fall, diff, hit;
    assign diff = s2[i] ^ lvl;
    assign hit = diff && cnt == CMAX;
    always_ff @(posedge clk)
      if (reset) {cnt, lvl, rise, fall} <= '0;
      else begin
        cnt <= diff && !hit ? cnt + 1'b1 : '0;
        lvl <= hit ? s2[i] : lvl;
        rise <= hit && s2[i];
        fall <= hit && !s2[i];
      end
    assign level_out[i] = lvl;
    assign rise_pulse[i] = rise;
    assign fall_pulse[i] = fall;
    if (LONG_CYCLES > 0) begin : g_long
      localparam int HW = $clog2(LONG_CYCLES + 1);
      localparam logic [HW-1:0] HMAX = HW'(LONG_CYCLES - 1);
      logic [HW-1:0] hcnt;
      logic fired, lp, top;
      assign top = hcnt == HMAX;
      always_ff @(posedge clk)
        if (reset || !lvl || hit) {hcnt, fired, lp} <= '0;
        else begin
          lp <= top && !fired;
          fired <= fired || top;
          hcnt <= fired || top ? hcnt : hcnt + 1'b1;
        end
      assign long_press[i] = lp;
    end else begin : g_nolong
      assign long_press[i] = 1'b0;
    end
  end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: table-driven and hand-sequenced checks of debounce_bank against a cycle-scheduled event scoreboard
module tb_debounce_bank;
  localparam int S = 8;
  localparam int L = 32;
  typedef struct {int cyc; logic [7:0] r; logic [7:0] f; logic [7:0] l;} ev_t;
  typedef struct {logic [3:0] m; int w; bit er; bit el;} vec_t;
  logic clk, reset;
  logic [3:0] btn, btn_al;
  logic [3:0] lvl, rise, fall, lng;
  logic [3:0] lvl_al, rise_al, fall_al, lng_al;
  int cyc, n_run, n_fail;
  logic rst_edge, mon_en;
  logic [7:0] exp_lvl, er, ef, el;
  ev_t q[$];
  vec_t tbl[8];
  debounce_bank #(.CHANNELS(4), .STABLE_CYCLES(S), .LONG_CYCLES(L), .ACTIVE_LOW(0)) dut (
    .clk(clk), .reset(reset), .btn_in(btn),
    .level_out(lvl), .rise_pulse(rise), .fall_pulse(fall), .long_press(lng)
  );
  debounce_bank #(.CHANNELS(4), .STABLE_CYCLES(S), .LONG_CYCLES(L), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .reset(reset), .btn_in(btn_al),
    .level_out(lvl_al), .rise_pulse(rise_al), .fall_pulse(fall_al), .long_press(lng_al)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    cyc = 0;
    rst_edge = 1'b0;
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_edge <= reset;
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    n_run++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h want %h", name, cyc, act, want);
    end
  endtask
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(int at, logic [7:0] r, logic [7:0] f, logic [7:0] l);
    ev_t e;
    e.cyc = at;
    e.r = r;
    e.f = f;
    e.l = l;
    q.push_back(e);
  endtask
  task automatic pulse(logic [3:0] m, int w, bit exp_rise, bit exp_long);
    int c = cyc;
    btn = btn | m;
    if (exp_rise) begin
      push(c + S + 2, {4'h0, m}, 8'h00, 8'h00);
      push(c + w + S + 2, 8'h00, {4'h0, m}, 8'h00);
    end
    if (exp_long) push(c + S + 2 + L, 8'h00, 8'h00, {4'h0, m});
    tick(w);
    btn = btn & ~m;
    tick(20);
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      er = '0;
      ef = '0;
      el = '0;
      if (rst_edge) exp_lvl = '0;
      else begin
        for (int k = q.size() - 1; k >= 0; k--)
          if (q[k].cyc == cyc) begin
            er = er | q[k].r;
            ef = ef | q[k].f;
            el = el | q[k].l;
            q.delete(k);
          end
        exp_lvl = (exp_lvl | er) & ~ef;
      end
      chk("outputs", {lvl_al, lvl, rise_al, rise, fall_al, fall, lng_al, lng}, {exp_lvl, er, ef, el});
    end
  end
  initial begin
    int c;
    n_run = 0;
    n_fail = 0;
    mon_en = 1'b0;
    exp_lvl = '0;
    tbl[0] = '{4'b0010, 7, 1'b0, 1'b0};
    tbl[1] = '{4'b0010, 8, 1'b1, 1'b0};
    tbl[2] = '{4'b0100, 60, 1'b1, 1'b1};
    tbl[3] = '{4'b0100, 20, 1'b1, 1'b0};
    tbl[4] = '{4'b0100, 32, 1'b1, 1'b0};
    tbl[5] = '{4'b0100, 33, 1'b1, 1'b1};
    tbl[6] = '{4'b1001, 12, 1'b1, 1'b0};
    tbl[7] = '{4'b0001, 1, 1'b0, 1'b0};
    reset = 1'b1;
    btn = 4'hF;
    btn_al = 4'hF;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    tick(2);
    reset = 1'b0;
    push(cyc + S + 2, 8'h0F, 8'h00, 8'h00);
    push(cyc + S + 2 + L, 8'h00, 8'h00, 8'h0F);
    tick(47);
    btn = 4'h0;
    push(cyc + S + 2, 8'h00, 8'h0F, 8'h00);
    tick(20);
    for (int t = 0; t < 8; t++) pulse(tbl[t].m, tbl[t].w, tbl[t].er, tbl[t].el);
    for (int k = 0; k < 10; k++) begin
      btn[0] = (k % 2 == 0);
      tick(3);
    end
    btn[0] = 1'b1;
    push(cyc + S + 2, 8'h01, 8'h00, 8'h00);
    tick(20);
    btn[0] = 1'b0;
    push(cyc + S + 2, 8'h00, 8'h01, 8'h00);
    tick(20);
    c = cyc;
    btn = 4'b1001;
    push(c + S + 2, 8'h09, 8'h00, 8'h00);
    tick(32);
    btn[0] = 1'b0;
    push(c + 42, 8'h00, 8'h01, 8'h00);
    push(c + 42, 8'h00, 8'h00, 8'h08);
    tick(18);
    btn[3] = 1'b0;
    push(cyc + S + 2, 8'h00, 8'h08, 8'h00);
    tick(20);
    btn[1] = 1'b1;
    tick(5);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    push(cyc + S + 2, 8'h02, 8'h00, 8'h00);
    tick(15);
    btn[1] = 1'b0;
    push(cyc + S + 2, 8'h00, 8'h02, 8'h00);
    tick(20);
    btn[2] = 1'b1;
    push(cyc + S + 2, 8'h04, 8'h00, 8'h00);
    tick(20);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    push(cyc + S + 2, 8'h04, 8'h00, 8'h00);
    tick(15);
    btn[2] = 1'b0;
    push(cyc + S + 2, 8'h00, 8'h04, 8'h00);
    tick(20);
    btn_al[0] = 1'b0;
    push(cyc + S + 2, 8'h10, 8'h00, 8'h00);
    tick(10);
    btn_al[0] = 1'b1;
    push(cyc + S + 2, 8'h00, 8'h10, 8'h00);
    tick(25);
    chk("pending_events", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
